// File: rtl/key_repeat_filter.sv
// Debounces one active-low key; emits press/release pulses plus auto-repeat while held.
// Latency: flags appear DEBOUNCE_CYC+3 edges after the first edge that samples a new key level.
// Backpressure: none, all outputs are free-running single-cycle pulses or levels.
module key_repeat_filter #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int HOLD_CYC     = 25_000_000,
  parameter int REPEAT_CYC   = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  input  logic repeat_en,
  output logic key_state,
  output logic nege_flag,
  output logic pose_flag,
  output logic rep_flag
);

  localparam int MAX_AB = (DEBOUNCE_CYC > HOLD_CYC) ? DEBOUNCE_CYC : HOLD_CYC;
  localparam int MAX_CY = (MAX_AB > REPEAT_CYC) ? MAX_AB : REPEAT_CYC;
  localparam int CNT_W  = $clog2(MAX_CY) + 1;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILT_DN = 3'd1,
    HOLD    = 3'd2,
    REPEAT  = 3'd3,
    FILT_UP = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ks_meta;
  logic             ks;
  logic             key_lvl;
  logic             nege_q;
  logic             pose_q;
  logic             rep_q;

  // Two-flop synchronizer; idles high so a released key produces no event after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ks_meta <= 1'b1;
      ks      <= 1'b1;
    end else begin
      ks_meta <= key_in;
      ks      <= ks_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      key_lvl   <= 1'b1;
      nege_q    <= 1'b0;
      pose_q    <= 1'b0;
      rep_q     <= 1'b0;
      key_state <= 1'b1;
      nege_flag <= 1'b0;
      pose_flag <= 1'b0;
      rep_flag  <= 1'b0;
    end else begin
      key_state <= key_lvl;
      nege_flag <= nege_q;
      pose_flag <= pose_q;
      rep_flag  <= rep_q;
      nege_q    <= 1'b0;
      pose_q    <= 1'b0;
      rep_q     <= 1'b0;

      case (state)
        IDLE: begin
          if (!ks) begin
            state <= FILT_DN;
            cnt   <= '0;
          end
        end

        FILT_DN: begin
          if (ks) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state   <= HOLD;
            cnt     <= '0;
            key_lvl <= 1'b0;
            nege_q  <= 1'b1;
            rep_q   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        HOLD: begin
          if (ks) begin
            state <= FILT_UP;
            cnt   <= '0;
          end else if (cnt == HOLD_LAST) begin
            // Parked at the terminal so repeating starts the moment it is enabled.
            if (repeat_en) begin
              state <= REPEAT;
              cnt   <= '0;
              rep_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        REPEAT: begin
          if (ks) begin
            state <= FILT_UP;
            cnt   <= '0;
          end else if (!repeat_en) begin
            state <= HOLD;
            cnt   <= HOLD_LAST;
          end else if (cnt == REP_LAST) begin
            cnt   <= '0;
            rep_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        FILT_UP: begin
          if (!ks) begin
            state <= HOLD;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state   <= IDLE;
            cnt     <= '0;
            key_lvl <= 1'b1;
            pose_q  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_repeat_filter.sv
// Bench for key_repeat_filter: directed vector table, timed corner sequences and
// a randomized run against a timestamp-based behavioural model.
module tb_key_repeat_filter;
  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  logic clk = 1'b0;
  logic rst;
  logic key_in;
  logic repeat_en;
  logic key_state;
  logic nege_flag;
  logic pose_flag;
  logic rep_flag;

  always #5 clk = ~clk;

  key_repeat_filter #(.DEBOUNCE_CYC(DEB), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .repeat_en (repeat_en),
    .key_state (key_state),
    .nege_flag (nege_flag),
    .pose_flag (pose_flag),
    .rep_flag  (rep_flag)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural model: debounced level flips once DEB+1 consecutive synchronized
  // samples disagree with it; repeats are timed from timestamps of the hold start.
  logic m_meta, m_ks, m_deb, m_repeating;
  int   m_run, m_anchor, m_last, m_n;
  logic [3:0] m_int, m_exp;
  logic [3:0] prev_out;
  logic       next_is_nege;

  task automatic model_reset();
    m_meta = 1'b1; m_ks = 1'b1; m_deb = 1'b1; m_repeating = 1'b0;
    m_run = 0; m_anchor = 0; m_last = 0;
    m_int = 4'b1000; m_exp = 4'b1000;
    prev_out = 4'b1000; next_is_nege = 1'b1;
  endtask

  task automatic model_step(input logic k, input logic r);
    logic ks_used, fn, fp, fr;
    ks_used = m_ks; m_ks = m_meta; m_meta = k;
    fn = 1'b0; fp = 1'b0; fr = 1'b0;
    if (m_deb) begin
      if (!ks_used) begin
        m_run++;
        if (m_run == DEB + 1) begin
          m_deb = 1'b0; m_run = 0; fn = 1'b1; fr = 1'b1;
          m_anchor = m_n; m_repeating = 1'b0;
        end
      end else m_run = 0;
    end else begin
      if (ks_used) begin
        m_repeating = 1'b0;
        m_run++;
        if (m_run == DEB + 1) begin m_deb = 1'b1; m_run = 0; fp = 1'b1; end
      end else if (m_run > 0) begin
        m_run = 0; m_anchor = m_n; m_repeating = 1'b0;
      end else if (!m_repeating) begin
        if ((m_n - m_anchor) >= HOLD && r) begin fr = 1'b1; m_repeating = 1'b1; m_last = m_n; end
      end else if (!r) begin
        m_repeating = 1'b0; m_anchor = m_n - (HOLD - 1);
      end else if ((m_n - m_last) >= REP) begin
        fr = 1'b1; m_last = m_n;
      end
    end
    m_exp = m_int;
    m_int = {m_deb, fn, fp, fr};
    m_n++;
  endtask

  // One clock: drive, advance model, sample 1 time unit after the edge and compare.
  task automatic step(input logic k, input logic r, input string tag, output logic [3:0] o);
    key_in = k; repeat_en = r;
    @(posedge clk);
    model_step(k, r);
    #1;
    o = {key_state, nege_flag, pose_flag, rep_flag};
    check(tag, int'(o), int'(m_exp));
    if (o[2:0] != 3'b000) begin
      check("pulse_width", int'(o[2:0] & prev_out[2:0]), 0);
      check("pose_rep_overlap", int'(o[1] & o[0]), 0);
    end
    if (o[2] || o[1]) begin
      check("nege_pose_alternate", int'(o[2]), int'(next_is_nege));
      next_is_nege = o[1];
    end
    prev_out = o;
  endtask

  task automatic do_reset(input logic k);
    key_in = k;
    rst = 1'b1;
    model_reset();
    #1;
    check("reset_outputs", int'({key_state, nege_flag, pose_flag, rep_flag}), 4'b1000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       k;
    logic       r;
    logic [3:0] exp;
  } vec_t;

  initial begin
    vec_t       tbl[$];
    logic [3:0] o;
    int         reps[$];
    int         cnt_a, cnt_b, first_a;
    int         exp_rep3[9] = '{7, 17, 20, 23, 26, 29, 32, 35, 38};
    int         exp_rep6[3] = '{31, 34, 37};
    logic       lvl;
    int         seg;

    // Press held 20 cycles then released: nege+rep at 7, pose at 27.
    for (int e = 0; e < 35; e++)
      tbl.push_back('{(e < 20) ? 1'b0 : 1'b1, 1'b0,
                      {((e >= 7) && (e < 27)) ? 1'b0 : 1'b1, e == 7, e == 27, e == 7}});
    // Short presses and glitches: 3 low, single-cycle lows, and 4 low (one short of acceptance).
    for (int e = 0; e < 40; e++)
      tbl.push_back('{((e < 3) || (e == 9) || (e == 13) || ((e >= 17) && (e < 21))) ? 1'b0 : 1'b1,
                      1'b0, 4'b1000});

    rst = 1'b1; key_in = 1'b1; repeat_en = 1'b0;
    model_reset();
    #2;
    check("reset_async_start", int'({key_state, nege_flag, pose_flag, rep_flag}), 4'b1000);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "idle_after_reset", o);

    foreach (tbl[i]) begin
      key_in = tbl[i].k; repeat_en = tbl[i].r;
      @(posedge clk);
      model_step(tbl[i].k, tbl[i].r);
      #1;
      check($sformatf("vec%0d", i), int'({key_state, nege_flag, pose_flag, rep_flag}), int'(tbl[i].exp));
      prev_out = {key_state, nege_flag, pose_flag, rep_flag};
      if (prev_out[2] || prev_out[1]) next_is_nege = prev_out[1];
    end

    // Exactly DEB+1 low samples: accepted; immediate release gives pose at 12.
    first_a = -1; cnt_b = -1;
    for (int i = 0; i < 20; i++) begin
      step((i < 5) ? 1'b0 : 1'b1, 1'b0, "min_press", o);
      if (o[2]) first_a = i;
      if (o[1]) cnt_b = i;
    end
    check("min_press_nege_edge", first_a, 7);
    check("min_press_pose_edge", cnt_b, 12);

    // Held 40 cycles with repeat enabled.
    reps.delete(); cnt_a = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, "hold_repeat", o);
      if (o[0]) reps.push_back(i);
      if (o[2]) cnt_a++;
    end
    check("repeat_nege_count", cnt_a, 1);
    check("repeat_count", reps.size(), 9);
    foreach (exp_rep3[i]) check($sformatf("repeat_edge%0d", i), (i < reps.size()) ? reps[i] : -1, exp_rep3[i]);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, "release3", o);

    // Release bounce during HOLD restarts the hold delay.
    first_a = -1; cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 30; i++) begin
      step(((i == 10) || (i == 11)) ? 1'b1 : 1'b0, 1'b1, "hold_bounce", o);
      if (o[1]) cnt_a++;
      if (i >= 7 && o[3]) cnt_b++;
      if (i > 7 && o[0] && first_a < 0) first_a = i;
    end
    check("bounce_no_pose", cnt_a, 0);
    check("bounce_level_kept", cnt_b, 0);
    check("bounce_first_repeat", first_a, 25);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, "release4", o);

    // Reset while repeating, key held low.
    for (int i = 0; i < 22; i++) step(1'b0, 1'b1, "pre_reset", o);
    do_reset(1'b0);
    first_a = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, "post_reset", o);
      if (o[2] && first_a < 0) first_a = i;
    end
    check("post_reset_nege_edge", first_a, 7);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, "release5", o);

    // repeat_en dropped mid-REPEAT then re-raised.
    reps.delete();
    for (int i = 0; i < 40; i++) begin
      step(1'b0, ((i >= 21) && (i < 30)) ? 1'b0 : 1'b1, "repeat_toggle", o);
      if (i >= 21 && o[0]) reps.push_back(i);
    end
    check("toggle_repeat_count", reps.size(), 3);
    foreach (exp_rep6[i]) check($sformatf("toggle_edge%0d", i), (i < reps.size()) ? reps[i] : -1, exp_rep6[i]);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, "release6", o);

    // Randomized: mix of bounces and long holds, toggling repeat_en, rare resets.
    lvl = 1'b1; seg = 0;
    repeat_en = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        lvl = ~lvl;
        seg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 60));
      end
      seg--;
      if ($urandom_range(0, 19) == 0) repeat_en = ~repeat_en;
      if ($urandom_range(0, 599) == 0) do_reset(lvl);
      step(lvl, repeat_en, "random", o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
